config_word_loader: RTL and testbench

//  Writer side of the data_connection_block config port: assembles CONF_WIDTH config bits from a

---
 rtl/config_word_loader.sv | 97 +++++++++
 tb/tb_config_word_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/config_word_loader.sv
// rtl/config_word_loader.sv - config word bus writer for a data_connection_block config port
// Header selects target by ID, NWORDS payload words are assembled LSB-word-first, then cset strobes once.
module config_word_loader #(
  parameter int CONF_WIDTH = 288,
  parameter int IW         = 32,
  parameter int ID_WIDTH   = 8,
  parameter int ID         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  cset,
  output logic                  busy,
  output logic                  err
);

  localparam int NWORDS = (CONF_WIDTH + IW - 1) / IW;
  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam int AW     = NWORDS * IW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SKIP, COMMIT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [AW-1:0]     asm_q, asm_next;
  logic              cset_next, err_next;
  logic              transfer;
  logic [ID_WIDTH-1:0] hdr_id;

  assign in_ready = (state != COMMIT);
  assign busy     = (state != IDLE);
  assign transfer = in_valid && in_ready;
  assign hdr_id   = in_data[ID_WIDTH-1:0];
  assign c        = asm_q[CONF_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      asm_q <= '0;
      cset  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      asm_q <= asm_next;
      cset  <= cset_next;
      err   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    asm_next   = asm_q;
    cset_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          count_next = '0;
          if (!in_data[IW-1])
            err_next = 1'b1;
          else if (hdr_id == ID_WIDTH'(ID) || hdr_id == '1)
            state_next = LOAD;
          else
            state_next = SKIP;
        end
      end
      LOAD: begin
        if (transfer) begin
          // Shift right so the first payload word ends up in the lowest slice.
          asm_next   = {in_data, asm_q[AW-1:IW]};
          count_next = count + CNT_W'(1);
          if (count == LAST) begin
            state_next = COMMIT;
            cset_next  = 1'b1;
          end
        end
      end
      SKIP: begin
        if (transfer) begin
          count_next = count + CNT_W'(1);
          if (count == LAST)
            state_next = IDLE;
        end
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_config_word_loader.sv
// tb/tb_config_word_loader.sv - directed self-checking bench for config_word_loader
module tb_config_word_loader;

  localparam int CW = 288;
  localparam int NW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] c;
  logic          cset;
  logic          busy;
  logic          err;

  int tests = 0;
  int fails = 0;
  int cset_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  config_word_loader #(.CONF_WIDTH(CW), .IW(32), .ID_WIDTH(8), .ID(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .cset(cset), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cset) cset_cnt++;
    if (err) err_cnt++;
    if (cset && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns just after the posedge on which the word was accepted.
  task automatic put(input logic [31:0] w, input int gap);
    int tries;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    tries = 0;
    while (!in_ready && tries < 10) begin
      @(negedge clk);
      tries++;
    end
    chk("ready_wait", CW'(tries < 10), CW'(1));
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base,
                            input logic [31:0] step, input int maxgap);
    put(hdr, 0);
    for (int k = 0; k < NW; k++)
      put(base + k * step, (maxgap > 0) ? $urandom_range(1, maxgap) : 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [CW-1:0] model(input logic [31:0] base, input logic [31:0] step);
    logic [CW-1:0] m;
    m = '0;
    for (int k = 0; k < NW; k++) m[k*32 +: 32] = base + k * step;
    return m;
  endfunction

  // Called in the cycle right after the last payload transfer of an accepted frame.
  task automatic check_commit(input string tag, input logic [CW-1:0] exp);
    int n0;
    n0 = cset_cnt;
    chk({tag, "_cset"}, CW'(cset), CW'(1));
    chk({tag, "_ready"}, CW'(in_ready), CW'(0));
    chk({tag, "_c"}, c, exp);
    @(negedge clk);
    chk({tag, "_cset_off"}, CW'(cset), CW'(0));
    chk({tag, "_busy_off"}, CW'(busy), CW'(0));
    chk({tag, "_pulses"}, CW'(cset_cnt - n0), CW'(1));
    chk({tag, "_c_hold"}, c, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    logic [CW-1:0] exp;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_c", c, '0);
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_cset", CW'(cset), CW'(0));
    chk("rst_err", CW'(err), CW'(0));
    chk("rst_ready", CW'(in_ready), CW'(1));
    rst = 1'b0;

    // Own ID, back-to-back words.
    send_frame(32'h8000_0003, 32'h1000_0000, 32'h1, 0);
    chk("f1_lo", CW'(c[31:0]), CW'(32'h1000_0000));
    chk("f1_hi", CW'(c[287:256]), CW'(32'h1000_0008));
    check_commit("f1", model(32'h1000_0000, 32'h1));

    // Foreign ID is skipped, then own ID loads.
    do_reset();
    n0 = cset_cnt;
    put(32'h8000_0005, 0);
    for (int k = 0; k < NW; k++) begin
      put(32'h1000_0000 + k, 0);
      if (k == 4) begin
        @(negedge clk);
        chk("skip_busy", CW'(busy), CW'(1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("skip_busy_end", CW'(busy), CW'(0));
    chk("skip_cset", CW'(cset_cnt - n0), CW'(0));
    chk("skip_c", c, '0);
    send_frame(32'h8000_0003, 32'hA5A5_A5A5, 32'h0, 0);
    check_commit("f2", {NW{32'hA5A5_A5A5}});

    // Broadcast header.
    send_frame(32'h8000_00FF, 32'hFFFF_FFFF, 32'h0, 0);
    check_commit("bcast", '1);

    // Missing start flag in IDLE.
    n0 = err_cnt;
    put(32'h0000_0003, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_pulse", CW'(err), CW'(1));
    chk("err_busy", CW'(busy), CW'(0));
    @(negedge clk);
    chk("err_off", CW'(err), CW'(0));
    chk("err_count", CW'(err_cnt - n0), CW'(1));
    send_frame(32'h8000_0003, 32'h0123_4567, 32'h1111_1111, 0);
    check_commit("post_err", model(32'h0123_4567, 32'h1111_1111));

    // Gaps of 1-3 idle cycles between words.
    send_frame(32'h8000_0003, 32'h2000_0000, 32'h0000_0101, 3);
    check_commit("gaps", model(32'h2000_0000, 32'h0000_0101));

    // Reset mid-frame.
    n0 = cset_cnt;
    put(32'h8000_0003, 0);
    for (int k = 0; k < 4; k++) put(32'h3000_0000 + k, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_c", c, '0);
    chk("mid_rst_busy", CW'(busy), CW'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_nocset", CW'(cset_cnt - n0), CW'(0));
    send_frame(32'h8000_0003, 32'h4000_0000, 32'h3, 2);
    check_commit("after_rst", model(32'h4000_0000, 32'h3));

    chk("cset_err_overlap", CW'(both_cnt), CW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
